// File: rtl/rca_8bits_pkg.sv
// rca_8bits_pkg: shared width and reset constants for the ripple-carry adder
package rca_8bits_pkg;
  localparam int ADD_WIDTH = 8;
  localparam logic [ADD_WIDTH-1:0] RST_SUM = 8'h00;
endpackage

// File: rtl/rca_8bits_full_adder.sv
// full_adder: 1-bit gate-level full adder, one link of the ripple chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_p;
  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);
endmodule

// File: rtl/rca_8bits.sv
// rca_8bits: 8-bit ripple-carry adder with combinational result and registered copy plus signed overflow
module rca_8bits
  import rca_8bits_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  output logic             cout,
  output logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);
  logic [WIDTH:0] w_c;
  logic           w_ovf;
  assign w_c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a (x[i]),
      .b (y[i]),
      .ci(w_c[i]),
      .s (sum[i]),
      .co(w_c[i+1])
    );
  end
  assign cout  = w_c[WIDTH];
  // carries into and out of the sign bit disagree exactly on signed overflow
  assign w_ovf = w_c[WIDTH-1] ^ w_c[WIDTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= RST_SUM;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
      ovf_q  <= w_ovf;
    end
  end
endmodule

// File: tb/tb_rca_8bits.sv
// tb_rca_8bits: directed, random and exhaustive checks of rca_8bits against an arithmetic model
module tb_rca_8bits;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] x = '0, y = '0;
  logic       cin = 1'b0;
  logic       cout, cout_q, ovf_q;
  logic [7:0] sum, sum_q;
  int n_cmp = 0, n_bad = 0;

  rca_8bits dut (
    .cout(cout), .sum(sum), .x(x), .y(y), .cin(cin),
    .clk(clk), .rst(rst), .sum_q(sum_q), .cout_q(cout_q), .ovf_q(ovf_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (x=%h y=%h cin=%b rst=%b)", tag, got, exp, x, y, cin, rst);
    end
  endtask

  // {ovf, cout, sum} from plain unsigned and signed arithmetic
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
    int u, s;
    u = int'(a) + int'(b) + int'(c);
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return {(s > 127 || s < -128), u[8:0]};
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    x = a; y = b; cin = c;
    #1;
  endtask

  task automatic vec(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec, input logic eo);
    drive(a, b, c);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    @(posedge clk); #1;
    chk({tag, "_sum_q"}, 32'(sum_q), 32'(es));
    chk({tag, "_cout_q"}, 32'(cout_q), 32'(ec));
    chk({tag, "_ovf_q"}, 32'(ovf_q), 32'(eo));
  endtask

  initial begin
    logic [9:0] m;
    logic [9:0] e;
    logic       r;
    x = 8'h12; y = 8'h34;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum_q", 32'(sum_q), 32'h00);
    chk("rst_cout_q", 32'(cout_q), 32'h0);
    chk("rst_ovf_q", 32'(ovf_q), 32'h0);
    chk("rst_comb_sum", 32'(sum), 32'h46);
    @(negedge clk); rst = 1'b0;

    vec("f0_0f", 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0);
    vec("55_aa", 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0);
    vec("55_aa_c", 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);
    vec("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    vec("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    vec("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    vec("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    vec("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // registers hold 0x80/ovf, then reset clears them while comb follows new inputs
    vec("pre_rst", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    @(negedge clk);
    x = 8'hFF; y = 8'h01; cin = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_sum_q", 32'(sum_q), 32'h00);
    chk("mid_rst_cout_q", 32'(cout_q), 32'h0);
    chk("mid_rst_ovf_q", 32'(ovf_q), 32'h0);
    chk("mid_rst_sum", 32'(sum), 32'h00);
    chk("mid_rst_cout", 32'(cout), 32'h1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cout_q", 32'(cout_q), 32'h1);
    chk("post_rst_sum_q", 32'(sum_q), 32'h00);

    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(15) == 0);
      drive(8'($urandom), 8'($urandom), 1'($urandom));
      rst = r;
      m = model(x, y, cin);
      chk("rnd_sum", 32'(sum), 32'(m[7:0]));
      chk("rnd_cout", 32'(cout), 32'(m[8]));
      e = r ? 10'h0 : m;
      @(posedge clk); #1;
      chk("rnd_sum_q", 32'(sum_q), 32'(e[7:0]));
      chk("rnd_cout_q", 32'(cout_q), 32'(e[8]));
      chk("rnd_ovf_q", 32'(ovf_q), 32'(e[9]));
    end
    rst = 1'b0;

    for (int v = 0; v < (1 << 17); v++) begin
      {cin, x, y} = 17'(v);
      #1;
      m = model(x, y, cin);
      chk("exh", 32'({cout, sum}), 32'(m[8:0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rca_8bits.md
# rca_8bits

8-bit ripple-carry adder with carry-in and carry-out, built from a chain of eight 1-bit full adders. Sum and carry are available combinationally, and a registered copy of the result is provided for pipelined datapaths. It is the basic adder primitive for the arithmetic datapath. The combinational path works with the clock idle, so the block can also be used as a pure combinational adder.

## Interface
Parameters:
- WIDTH, 8, operand width; fixed at 8 for this block and not overridden.

Ports are declared in the order cout, sum, x, y, cin, clk, rst, sum_q, cout_q, ovf_q. Positional instantiation of the first five ports (cout, sum, x, y, cin) is supported. The bullets below list clock and reset first.
- clk  input  1  single clock; rising edge only.
- rst  input  1  reset; synchronous and active-high.
- cout  output  1  combinational carry out of bit 7.
- sum  output  8  combinational sum bits [7:0].
- x  input  8  operand A, unsigned or two's complement.
- y  input  8  operand B.
- cin  input  1  carry into bit 0.
- sum_q  output  8  registered sum.
- cout_q  output  1  registered carry out.
- ovf_q  output  1  registered signed overflow flag.

## Operation
- {cout, sum} = x + y + cin, a 9-bit exact result with no saturation; wrap-around is modulo 256 with the carry in cout.
- Ripple structure: c[0] = cin and c[i+1] = carry of full adder i; cout = c[8].
- Full adder i:
  - s = x[i] ^ y[i] ^ c[i]
  - co = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]))
- Signed overflow ovf = c[7] ^ c[8], which is 1 when both operands have the same sign and the sum sign differs.
- Inputs may change at any time; the combinational outputs follow after the ripple delay, with no latching.
- The registers hold their value until the next rising clk edge.
- X or Z on an input may propagate to the outputs; no input checking is performed.

## Timing
- sum and cout: zero-cycle latency, pure combinational. Worst-case path is cin -> c[8] through 8 full adders.
- sum_q, cout_q, ovf_q: 1-cycle latency. They capture the combinational result at each rising clk edge when rst = 0.
- Reset, when rst = 1 at a rising edge: sum_q = 0x00, cout_q = 0, ovf_q = 0.
  - Reset has priority over capture.
  - Reset does not affect sum or cout, which always reflect the current inputs.
- Reset asserted mid-stream clears the registers at that edge. The first capture after rst deasserts occurs at the following edge.
- No handshake: a result is captured every cycle and there is no valid or ready signalling.
- Before the first clk edge, the registered outputs are undefined unless reset has been applied. When clk is never toggled, only sum and cout are meaningful.

## Structure
- Sub-module full_adder (ports: a, b, ci, s, co) is instantiated 8 times via a generate loop or explicit instances. The internal carry chain c[8:0] is a wire vector.
- Output registers live in one always block in rca_8bits.
- Shared package holds ADD_WIDTH = 8 and the reset constant RST_SUM = 8'h00. No typedefs are needed.
- No behavioural "+" is allowed in the RTL datapath; the gate-level ripple is the requirement. A behavioural model is permitted in the bench only.

## Test plan
- x = 0xF0, y = 0x0F, cin = 0 -> sum = 0xFF, cout = 0, ovf = 0. After one clk: sum_q = 0xFF, cout_q = 0.
- x = 0x55, y = 0xAA, cin = 0 -> sum = 0xFF, cout = 0. Then with cin = 1 -> sum = 0x00, cout = 1, full carry ripple from bit 0 to bit 8.
- Wrap and signed overflow:
  - x = 0xFF, y = 0x01, cin = 0 -> sum = 0x00, cout = 1, ovf_q = 0.
  - x = 0x7F, y = 0x01 -> sum = 0x80, cout = 0, ovf_q = 1.
  - x = 0x80, y = 0x80 -> sum = 0x00, cout = 1, ovf_q = 1.
- Boundary: x = 0xFF, y = 0xFF, cin = 1 -> sum = 0xFF, cout = 1. x = 0, y = 0, cin = 0 -> sum = 0x00, cout = 0.
- Reset:
  - Load 0xFF + 0x01, then assert rst for one edge -> sum_q = 0x00, cout_q = 0, ovf_q = 0, while sum = 0x00 and cout = 1 remain combinational.
  - Deassert rst -> registers reload the current result at the next edge.
- Exhaustive/random: all 2^17 input combinations checked against x + y + cin on the combinational outputs. The registered outputs are checked one cycle later.
